// File: rtl/pic_control_sequencer_if.sv
// CPU/acknowledge bus and datapath control bundle for pic_control_sequencer.
// master = CPU / interrupt-block side, slave = sequencer side.
interface pic_control_sequencer_if;
  logic       wr_en;
  logic       a0;
  logic [7:0] din;
  logic       inta;
  logic       int_req;
  logic [2:0] chosen;
  logic       int_out;
  logic       ltim;
  logic [7:0] mask;
  logic [7:0] irr_clr;
  logic [7:0] isr;
  logic       rot_mode;
  logic       rot_pulse;
  logic [2:0] rot_level;
  logic [7:0] dout;
  logic       dout_valid;
  logic       init_done;

  modport master (
    output wr_en, a0, din, inta, int_req, chosen,
    input  int_out, ltim, mask, irr_clr, isr, rot_mode, rot_pulse, rot_level,
           dout, dout_valid, init_done
  );

  modport slave (
    input  wr_en, a0, din, inta, int_req, chosen,
    output int_out, ltim, mask, irr_clr, isr, rot_mode, rot_pulse, rot_level,
           dout, dout_valid, init_done
  );
endinterface

// File: rtl/pic_control_sequencer.sv
// 8259-style init/command decoder, two-pulse INTA sequencer and in-service register.
// All outputs are registered; next values are formed in one combinational block.
module pic_control_sequencer (
  input logic                    clk,
  input logic                    rst,
  pic_control_sequencer_if.slave bus
);
  localparam int unsigned NLVL = 8;

  typedef enum logic [1:0] {UNINIT, WAIT_ICW2, WAIT_ICW4, READY} init_state_t;
  typedef enum logic {IDLE, WAIT2} ack_state_t;

  init_state_t init_state, init_state_n;
  ack_state_t  ack_state, ack_state_n;

  logic            icw4_needed, icw4_needed_n;
  logic [4:0]      base, base_n;
  logic            aeoi, aeoi_n;
  logic [2:0]      lvl, lvl_n;
  logic            spur, spur_n;
  logic            int_out, int_out_n;
  logic            ltim, ltim_n;
  logic [NLVL-1:0] mask, mask_n;
  logic [NLVL-1:0] irr_clr, irr_clr_n;
  logic [NLVL-1:0] isr, isr_n;
  logic            rot_mode, rot_mode_n;
  logic            rot_pulse, rot_pulse_n;
  logic [2:0]      rot_level, rot_level_n;
  logic [7:0]      dout, dout_n;
  logic            dout_valid, dout_valid_n;
  logic            init_done, init_done_n;

  logic            icw1;
  logic [NLVL-1:0] set_vec, clr_vec, le_mask;
  logic [2:0]      low_idx;
  logic            low_found, nest_ok;
  logic            ocw_rot, ack_rot;
  logic [2:0]      ocw_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      init_state  <= UNINIT;
      ack_state   <= IDLE;
      icw4_needed <= 1'b0;
      base        <= '0;
      aeoi        <= 1'b0;
      lvl         <= '0;
      spur        <= 1'b0;
      int_out     <= 1'b0;
      ltim        <= 1'b0;
      mask        <= '0;
      irr_clr     <= '0;
      isr         <= '0;
      rot_mode    <= 1'b0;
      rot_pulse   <= 1'b0;
      rot_level   <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      init_state  <= init_state_n;
      ack_state   <= ack_state_n;
      icw4_needed <= icw4_needed_n;
      base        <= base_n;
      aeoi        <= aeoi_n;
      lvl         <= lvl_n;
      spur        <= spur_n;
      int_out     <= int_out_n;
      ltim        <= ltim_n;
      mask        <= mask_n;
      irr_clr     <= irr_clr_n;
      isr         <= isr_n;
      rot_mode    <= rot_mode_n;
      rot_pulse   <= rot_pulse_n;
      rot_level   <= rot_level_n;
      dout        <= dout_n;
      dout_valid  <= dout_valid_n;
      init_done   <= init_done_n;
    end
  end

  always_comb begin
    init_state_n  = init_state;
    ack_state_n   = ack_state;
    icw4_needed_n = icw4_needed;
    base_n        = base;
    aeoi_n        = aeoi;
    lvl_n         = lvl;
    spur_n        = spur;
    ltim_n        = ltim;
    mask_n        = mask;
    isr_n         = isr;
    rot_mode_n    = rot_mode;
    dout_n        = dout;
    irr_clr_n     = '0;
    rot_pulse_n   = 1'b0;
    rot_level_n   = '0;
    dout_valid_n  = 1'b0;
    set_vec       = '0;
    clr_vec       = '0;
    ocw_rot       = 1'b0;
    ocw_lvl       = '0;
    ack_rot       = 1'b0;
    low_idx       = '0;
    le_mask       = '0;

    icw1 = bus.wr_en & ~bus.a0 & bus.din[4];

    // Descending scan so the lowest-indexed set bit is the one left in low_idx.
    for (int i = NLVL - 1; i >= 0; i--) begin
      if (isr[i]) low_idx = 3'(i);
    end
    low_found = |isr;

    for (int i = 0; i < NLVL; i++) begin
      le_mask[i] = (3'(i) <= bus.chosen);
    end
    nest_ok   = rot_mode ? (isr == '0) : ((isr & le_mask) == '0);
    int_out_n = init_done & bus.int_req & (ack_state == IDLE) & ~bus.inta & nest_ok;

    if (icw1) begin
      ltim_n        = bus.din[3];
      icw4_needed_n = bus.din[0];
      mask_n        = '0;
      isr_n         = '0;
      aeoi_n        = 1'b0;
      rot_mode_n    = 1'b0;
      ack_state_n   = IDLE;
      init_state_n  = WAIT_ICW2;
    end else begin
      if (bus.wr_en) begin
        case (init_state)
          WAIT_ICW2: if (bus.a0) begin
            base_n       = bus.din[7:3];
            init_state_n = icw4_needed ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (bus.a0) begin
            aeoi_n       = bus.din[1];
            init_state_n = READY;
          end
          READY: begin
            if (bus.a0) begin
              mask_n = bus.din;
            end else if (bus.din[4:3] == 2'b00) begin
              case (bus.din[7:5])
                3'b001: if (low_found) clr_vec = 8'b1 << low_idx;
                3'b011: clr_vec = 8'b1 << bus.din[2:0];
                3'b101: if (low_found) begin
                  clr_vec = 8'b1 << low_idx;
                  ocw_rot = 1'b1;
                  ocw_lvl = low_idx;
                end
                3'b111: begin
                  clr_vec = 8'b1 << bus.din[2:0];
                  ocw_rot = 1'b1;
                  ocw_lvl = bus.din[2:0];
                end
                3'b100:  rot_mode_n = 1'b1;
                3'b000:  rot_mode_n = 1'b0;
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end

      // Acknowledge: first pulse latches the level, second presents the vector.
      if (bus.inta && init_done) begin
        case (ack_state)
          IDLE: begin
            spur_n      = ~bus.int_req;
            lvl_n       = bus.int_req ? bus.chosen : 3'd7;
            if (bus.int_req) begin
              set_vec   = 8'b1 << bus.chosen;
              irr_clr_n = 8'b1 << bus.chosen;
            end
            ack_state_n = WAIT2;
          end
          WAIT2: begin
            dout_n       = {base, lvl};
            dout_valid_n = 1'b1;
            if (aeoi && !spur) begin
              clr_vec = clr_vec | (8'b1 << lvl);
              ack_rot = rot_mode;
            end
            ack_state_n  = IDLE;
          end
          default: ;
        endcase
      end

      isr_n = (isr & ~clr_vec) | set_vec;

      if (ocw_rot) begin
        rot_pulse_n = 1'b1;
        rot_level_n = ocw_lvl;
      end else if (ack_rot) begin
        rot_pulse_n = 1'b1;
        rot_level_n = lvl;
      end
    end

    init_done_n = (init_state_n == READY);
  end

  assign bus.int_out    = int_out;
  assign bus.ltim       = ltim;
  assign bus.mask       = mask;
  assign bus.irr_clr    = irr_clr;
  assign bus.isr        = isr;
  assign bus.rot_mode   = rot_mode;
  assign bus.rot_pulse  = rot_pulse;
  assign bus.rot_level  = rot_level;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.init_done  = init_done;
endmodule

// File: doc/pic_control_sequencer.md
# pic_control_sequencer

Control and acknowledge sequencer for the 8259-style interrupt block. It decodes the ICW1/ICW2/ICW4 initialization sequence and the OCW1/OCW2 command writes. It runs the two-pulse INTA acknowledge cycle and owns the in-service register. It drives mask, trigger mode, IRR clear, rotation control and the vector byte into the IRR / priority resolver datapath.

## Interface
Parameters:
- none; single chip, 8086 mode, no cascade.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; **synchronous, active-high**
- wr_en  in  1  one-cycle CPU write strobe
- a0  in  1  register address bit for the write
- din  in  8  CPU write data
- inta  in  1  one-cycle acknowledge strobe, one per INTA pulse
- int_req  in  1  "IRR has a pending request", from interrupt block
- chosen  in  3  resolved highest-priority level, from priority resolver
- int_out  out  1  interrupt request to CPU, registered
- ltim  out  1  1 = level-triggered, 0 = edge-triggered (IRR mode select)
- mask  out  8  IMR to IRR
- irr_clr  out  8  one-hot IRR bit clear, one-cycle pulse
- isr  out  8  in-service register
- rot_mode  out  1  rotate-in-AEOI flag to resolver
- rot_pulse  out  1  one-cycle rotate command to resolver
- rot_level  out  3  level that becomes lowest priority on rot_pulse
- dout  out  8  vector byte
- dout_valid  out  1  one-cycle qualifier for dout
- init_done  out  1  initialization complete

## Operation
- **Reset values:** all outputs are 0; init state is UNINIT and ack state is IDLE.
- **Init FSM.** States: UNINIT, WAIT_ICW2, WAIT_ICW4, READY.
  - ICW1 is a write with a0=0 and din[4]=1. It is accepted in any state. It sets ltim=din[3] and saves icw4_needed=din[0]. It clears mask, isr, aeoi, rot_mode, init_done and the ack FSM (abort), then goes to WAIT_ICW2.
  - WAIT_ICW2, write with a0=1: base=din[7:3]. Next state is WAIT_ICW4 if icw4_needed, else READY.
  - WAIT_ICW4, write with a0=1: aeoi=din[1]. Next state is READY.
  - Entering READY sets init_done=1.
  - Writes other than ICW1 before READY are ignored.
- **OCW1** (READY, a0=1): mask=din.
- **OCW2** (READY, a0=0, din[4:3]=00). Command is din[7:5]:
  - 001: non-specific EOI. Clears the lowest-indexed set isr bit.
  - 011: specific EOI. Clears isr[din[2:0]].
  - 101: rotate on non-specific EOI. Clears lowest set bit L; pulses rot_pulse with rot_level=L. If isr=0, no pulse.
  - 111: rotate on specific EOI. Clears isr[din[2:0]]; pulses with rot_level=din[2:0].
  - 100: rot_mode=1.
  - 000: rot_mode=0.
  - Other codes, and OCW3 (din[4:3]=01), are no-ops.
- **Ack FSM.** States: IDLE, WAIT2.
  - IDLE + inta: latch lvl=chosen if int_req=1, else lvl=7 (spurious).
    - Non-spurious: set isr[lvl] and pulse irr_clr[lvl].
    - Spurious: leave isr and irr_clr untouched.
    - Next state is WAIT2.
  - WAIT2 + inta: dout={base,lvl} and dout_valid=1. Next state is IDLE.
    - If aeoi and non-spurious: clear isr[lvl].
    - If aeoi, non-spurious and rot_mode: also pulse rot_pulse with rot_level=lvl.
  - inta while init_done=0 is ignored.
- **int_out (registered).** Next value is 1 only when all of these hold:
  - init_done
  - int_req
  - ack state IDLE
  - no inta this cycle
  - nesting check: fixed mode (rot_mode=0) requires no isr bit at index ≤ chosen; rotate mode requires isr=0.
- **Simultaneous EOI + INTA in one cycle:** isr_next=(isr & ~clr_vec) | set_vec, so set wins on the same bit. If both request rot_pulse, the OCW2 rotate wins.
- **ICW1 in the same cycle as inta:** ICW1 wins and the inta is dropped.

## Timing
- Config registers (mask, ltim, base, aeoi, rot_mode) are visible the cycle after wr_en.
- irr_clr and the isr set are visible the cycle after the first inta.
- dout/dout_valid are valid exactly one cycle, the cycle after the second inta.
- int_out falls the cycle after the first inta. The earliest re-assertion is the cycle after the second inta has been sampled, when the next cycle's conditions hold.
- EOI clears isr the cycle after wr_en.
- rst overrides everything in the same edge, including mid-init and mid-ack.

## Test plan
- **ICW1=0x13 (edge, ICW4), ICW2=0x40, ICW4=0x01:** init_done=1 after 3rd write; ltim=0; aeoi=0.
- **Ready, chosen=3, int_req=1 → int_out=1. Two inta strobes:**
  - After 1st: isr=0x08, irr_clr=0x08 for one cycle, int_out=0.
  - After 2nd: dout=0x43, dout_valid=1 for one cycle.
- **Nesting:** with isr=0x08, chosen=5 → int_out stays 0; chosen=1 → int_out=1. Then OCW2=0x20 → isr=0x00.
- **Spurious + AEOI:**
  - Init with ICW4=0x03, then inta with int_req=0: isr unchanged; dout=0x47 after 2nd inta.
  - Normal ack of level 2: isr bit 2 set after 1st inta, cleared after 2nd.
- **Rotation:** OCW2=0xE4 with isr=0x10 → isr=0x00, rot_pulse=1, rot_level=4 for one cycle.
- **Abort:** ICW1 written while ack FSM in WAIT2, then inta → no dout_valid; mask=0, isr=0, init_done=0. Separately, rst mid-ICW sequence returns all outputs to 0.
